// File: rtl/axi4_burst_writer.sv
// AXI4 write-only burst master: takes one (address, length) command, streams source words
// into a single INCR burst through a one-entry output register, then collects the write response.
module axi4_burst_writer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MAX_BEATS          = 64
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                        cmd_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic                              done,
    output logic                              err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK = C_M_AXI_ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                      len_q, len_d;
    logic [8:0]                      cnt_q, cnt_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                            wvalid_q, wvalid_d;
    logic                            wlast_q, wlast_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    logic        cmdIllegal;
    logic [31:0] burstBytes;
    logic [31:0] endOffset;
    logic        sLoad;
    logic        wFire;

    // A command is rejected if too long, misaligned, or if it would run past a 4 KB page.
    always_comb begin
        burstBytes = (32'(cmd_len) + 32'd1) << SIZE;
        endOffset  = 32'(cmd_addr[11:0]) + burstBytes;
        cmdIllegal = ((32'(cmd_len) + 32'd1) > 32'(MAX_BEATS))
                  || ((cmd_addr & ALIGN_MASK) != '0)
                  || (endOffset > 32'd4096);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            wlast_q  <= wlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid && !cmdIllegal) state_d = ADDR;
            ADDR:    if (M_AXI_AWREADY) state_d = DATA;
            DATA:    if (wvalid_q && M_AXI_WREADY && wlast_q) state_d = RESP;
            RESP:    if (M_AXI_BVALID) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus handshake outputs; s_ready lets a new word in whenever the output register is free or draining.
    always_comb begin
        cmd_ready     = (state_q == IDLE);
        M_AXI_AWVALID = (state_q == ADDR);
        M_AXI_BREADY  = (state_q == RESP);
        s_ready       = (state_q == DATA) && (cnt_q <= {1'b0, len_q})
                     && (!wvalid_q || M_AXI_WREADY);
    end

    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        wlast_d  = wlast_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        sLoad    = s_valid && s_ready;
        wFire    = wvalid_q && M_AXI_WREADY;

        if (state_q == IDLE && cmd_valid) begin
            if (cmdIllegal) begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end else begin
                addr_d = cmd_addr;
                len_d  = cmd_len;
                cnt_d  = '0;
            end
        end

        if (sLoad) begin
            wdata_d  = s_data;
            wvalid_d = 1'b1;
            wlast_d  = (cnt_q == {1'b0, len_q});
            cnt_d    = cnt_q + 9'd1;
        end else if (wFire) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
        end

        if (state_q == RESP && M_AXI_BVALID) begin
            done_d = 1'b1;
            err_d  = (M_AXI_BRESP != 2'b00);
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = 3'(SIZE);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
